// File: rtl/axi_mem_arbiter_if.sv
// Signal bundle between the IFU/LSU requesters, the memory arbiter and its AXI4-lite slave.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; rsp_valid pulses carry no ready.
interface axi_mem_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [63:0] ifu_rdata;
    logic [1:0]  ifu_rresp;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_wen;
    logic [31:0] lsu_addr;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wstrb;
    logic        lsu_rsp_valid;
    logic [63:0] lsu_rdata;
    logic [1:0]  lsu_resp;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rresp,
        input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wstrb,
        output lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_resp,
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rresp,
        output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wstrb,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_resp,
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_mem_arbiter.sv
// Arbitrates IFU reads and LSU reads/writes onto one AXI4-lite master port,
// one transaction in flight at a time; responses return as one-cycle pulses.
module axi_mem_arbiter #(
    parameter bit LSU_PRIO = 1'b1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axi_mem_arbiter_if.master    bus,
    output logic [2:0]           state_dbg
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW_W = 3'd3,
        B    = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic        owner_q;
    logic        rr_q;
    logic        aw_done;
    logic        w_done;

    logic        tie;
    logic        grant_lsu;
    logic        grant_ifu;
    logic        accept;
    logic        wen_sel;

    // rr_q = 1 means the LSU wins the next tie; only consulted when LSU_PRIO = 0.
    always_comb begin
        tie       = bus.ifu_req_valid && bus.lsu_req_valid;
        grant_lsu = (state == IDLE) && bus.lsu_req_valid &&
                    (!bus.ifu_req_valid || LSU_PRIO || rr_q);
        grant_ifu = (state == IDLE) && bus.ifu_req_valid && !grant_lsu;
        accept    = grant_lsu || grant_ifu;
        wen_sel   = grant_lsu && bus.lsu_wen;
    end

    assign bus.ifu_req_ready = grant_ifu;
    assign bus.lsu_req_ready = grant_lsu;
    assign bus.araddr        = addr_q;
    assign bus.awaddr        = addr_q;
    assign bus.wdata         = wdata_q;
    assign bus.wstrb         = wstrb_q;
    assign state_dbg         = state;

    always_comb begin
        state_next  = state;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        unique case (state)
            IDLE: if (accept) state_next = wen_sel ? AW_W : AR;
            AR: begin
                bus.arvalid = 1'b1;
                if (bus.arready) state_next = R;
            end
            R: begin
                bus.rready = 1'b1;
                if (bus.rvalid) state_next = IDLE;
            end
            AW_W: begin
                bus.awvalid = !aw_done;
                bus.wvalid  = !w_done;
                if ((aw_done || bus.awready) && (w_done || bus.wready)) state_next = B;
            end
            B: begin
                bus.bready = 1'b1;
                if (bus.bvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state             <= IDLE;
            addr_q            <= '0;
            wdata_q           <= '0;
            wstrb_q           <= '0;
            owner_q           <= 1'b0;
            rr_q              <= 1'b0;
            aw_done           <= 1'b0;
            w_done            <= 1'b0;
            bus.ifu_rsp_valid <= 1'b0;
            bus.ifu_rdata     <= '0;
            bus.ifu_rresp     <= '0;
            bus.lsu_rsp_valid <= 1'b0;
            bus.lsu_rdata     <= '0;
            bus.lsu_resp      <= '0;
        end else begin
            state             <= state_next;
            bus.ifu_rsp_valid <= 1'b0;
            bus.lsu_rsp_valid <= 1'b0;

            // Request inputs are sampled only here; the IFU can never reach AW/W.
            if (accept) begin
                addr_q  <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
                wdata_q <= wen_sel ? bus.lsu_wdata : '0;
                wstrb_q <= wen_sel ? bus.lsu_wstrb : '0;
                owner_q <= grant_lsu;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (tie && !LSU_PRIO) rr_q <= grant_ifu;
            end

            if (state == AW_W) begin
                if (bus.awvalid && bus.awready) aw_done <= 1'b1;
                if (bus.wvalid && bus.wready)   w_done  <= 1'b1;
            end

            if (state == R && bus.rvalid) begin
                if (owner_q) begin
                    bus.lsu_rsp_valid <= 1'b1;
                    bus.lsu_rdata     <= bus.rdata;
                    bus.lsu_resp      <= bus.rresp;
                end else begin
                    bus.ifu_rsp_valid <= 1'b1;
                    bus.ifu_rdata     <= bus.rdata;
                    bus.ifu_rresp     <= bus.rresp;
                end
            end

            if (state == B && bus.bvalid) begin
                bus.lsu_rsp_valid <= 1'b1;
                bus.lsu_rdata     <= '0;
                bus.lsu_resp      <= bus.bresp;
            end
        end
    end
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: a fixed-priority instance for the transaction
// scenarios and a round-robin instance for tie alternation.
module tb_axi_mem_arbiter;
    logic aclk = 1'b0;
    logic aresetn;
    logic [2:0] st;
    logic [2:0] st_rr;

    always #5 aclk = ~aclk;

    axi_mem_arbiter_if bus();
    axi_mem_arbiter_if bus_rr();

    axi_mem_arbiter #(.LSU_PRIO(1'b1)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus.master), .state_dbg(st)
    );
    axi_mem_arbiter #(.LSU_PRIO(1'b0)) dut_rr (
        .aclk(aclk), .aresetn(aresetn), .bus(bus_rr.master), .state_dbg(st_rr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [66:0] exp_q[$];
    logic [0:0]  exp_rr_q[$];
    bit          rr_order[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_rsp(bit lsu, logic [1:0] resp, logic [63:0] data);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got owner %0d data %0h with nothing expected at %0t",
                     lsu, data, $time);
        end else begin
            check("rsp", {lsu, resp, data}, exp_q.pop_front());
        end
    endfunction

    // Response monitor: pops one expectation per rsp pulse.
    always @(negedge aclk) begin
        if (bus.ifu_rsp_valid) check_rsp(1'b0, bus.ifu_rresp, bus.ifu_rdata);
        if (bus.lsu_rsp_valid) check_rsp(1'b1, bus.lsu_resp, bus.lsu_rdata);
    end

    // Grant monitor for the round-robin instance.
    always @(negedge aclk) begin
        if ((bus_rr.ifu_req_valid && bus_rr.ifu_req_ready) ||
            (bus_rr.lsu_req_valid && bus_rr.lsu_req_ready)) begin
            if (exp_rr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: got a grant with nothing expected at %0t", $time);
            end else begin
                logic [0:0] e;
                e = exp_rr_q.pop_front();
                check("rr_grant", {bus_rr.ifu_req_ready, bus_rr.lsu_req_ready}, {~e, e});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic init_drives();
        bus.ifu_req_valid = 0; bus.ifu_addr = '0;
        bus.lsu_req_valid = 0; bus.lsu_wen = 0; bus.lsu_addr = '0;
        bus.lsu_wdata = '0; bus.lsu_wstrb = '0;
        bus.arready = 0; bus.rdata = '0; bus.rresp = '0; bus.rvalid = 0;
        bus.awready = 0; bus.wready = 0; bus.bresp = '0; bus.bvalid = 0;
        bus_rr.ifu_req_valid = 0; bus_rr.ifu_addr = '0;
        bus_rr.lsu_req_valid = 0; bus_rr.lsu_wen = 0; bus_rr.lsu_addr = '0;
        bus_rr.lsu_wdata = '0; bus_rr.lsu_wstrb = '0;
        bus_rr.arready = 1; bus_rr.rdata = '0; bus_rr.rresp = '0; bus_rr.rvalid = 0;
        bus_rr.awready = 0; bus_rr.wready = 0; bus_rr.bresp = '0; bus_rr.bvalid = 0;
    endtask

    task automatic do_read(input bit lsu, input logic [31:0] a, input logic [63:0] d,
                           input logic [1:0] resp, input int ar_wait);
        int n = 0;
        if (lsu) begin
            bus.lsu_req_valid = 1; bus.lsu_wen = 0; bus.lsu_addr = a;
        end else begin
            bus.ifu_req_valid = 1; bus.ifu_addr = a;
        end
        bus.arready = (ar_wait == 0);
        #1;
        while (!(lsu ? bus.lsu_req_ready : bus.ifu_req_ready) && n < 20) begin
            tick();
            n++;
        end
        check("grant_seen", (n < 20), 1'b1);
        check("other_ready", lsu ? bus.ifu_req_ready : bus.lsu_req_ready, 1'b0);
        exp_q.push_back({lsu, resp, d});
        tick();
        if (lsu) bus.lsu_req_valid = 0; else bus.ifu_req_valid = 0;
        for (int k = 0; k < ar_wait; k++) begin
            check("ar_hold", {bus.arvalid, bus.araddr, bus.ifu_req_ready, bus.lsu_req_ready},
                  {1'b1, a, 2'b00});
            tick();
        end
        bus.arready = 1;
        check("ar_valid", {bus.arvalid, bus.araddr, bus.awvalid}, {1'b1, a, 1'b0});
        tick();
        check("r_phase", {st, bus.rready}, {3'd2, 1'b1});
        bus.rvalid = 1; bus.rdata = d; bus.rresp = resp;
        tick();
        bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0;
        check("rsp_pulse", lsu ? bus.lsu_rsp_valid : bus.ifu_rsp_valid, 1'b1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input int aw_lat, input int w_lat, input logic [1:0] bresp);
        int last = (aw_lat > w_lat) ? aw_lat : w_lat;
        bus.lsu_req_valid = 1; bus.lsu_wen = 1; bus.lsu_addr = a;
        bus.lsu_wdata = d; bus.lsu_wstrb = s;
        #1;
        check("wr_grant", {bus.lsu_req_ready, bus.ifu_req_ready}, 2'b10);
        exp_q.push_back({1'b1, bresp, 64'h0});
        tick();
        bus.lsu_req_valid = 0; bus.lsu_wen = 0;
        check("wr_payload", {bus.arvalid, bus.awaddr, bus.wdata, bus.wstrb}, {1'b0, a, d, s});
        for (int k = 0; k <= last; k++) begin
            check("aw_valid", bus.awvalid, (k <= aw_lat));
            check("w_valid", bus.wvalid, (k <= w_lat));
            bus.awready = (k == aw_lat);
            bus.wready  = (k == w_lat);
            tick();
        end
        bus.awready = 0; bus.wready = 0;
        check("b_phase", {bus.awvalid, bus.wvalid, bus.bready, st}, {3'b001, 3'd4});
        bus.bvalid = 1; bus.bresp = bresp;
        tick();
        bus.bvalid = 0; bus.bresp = '0;
        check("b_pulse", bus.lsu_rsp_valid, 1'b1);
    endtask

    initial begin
        init_drives();
        aresetn = 1;
        #2 aresetn = 0;
        #1;
        check("rst_state", {st, st_rr}, 6'd0);
        check("rst_axi_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 5'd0);
        check("rst_rsp", {bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.araddr, bus.lsu_rdata}, 98'd0);
        check("rst_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b00);
        repeat (2) tick();
        aresetn = 1;
        tick();

        // Zero-wait IFU read: arvalid at T+1, pulse at T+3.
        do_read(1'b0, 32'h8000_0000, 64'h0000_0013_0000_0297, 2'b00, 0);

        // Writes: AW first by two cycles, W first, and both together.
        do_write(32'h8000_1000, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 0, 2, 2'b10);
        do_write(32'h8000_2000, 64'h0123_4567_89AB_CDEF, 8'hF0, 1, 0, 2'b00);
        do_write(32'h8000_3008, 64'h5555_AAAA_5555_AAAA, 8'hFF, 0, 0, 2'b00);

        // Tie with fixed LSU priority, then IFU; second tie with a 5-cycle AR stall.
        tick();
        bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0040;
        do_read(1'b1, 32'h8000_4000, 64'h1111_2222_3333_4444, 2'b00, 0);
        do_read(1'b0, 32'h8000_0040, 64'h0000_0000_0000_0073, 2'b00, 0);
        tick();
        bus.ifu_req_valid = 1; bus.ifu_addr = 32'h8000_0080;
        do_read(1'b1, 32'h8000_5000, 64'hFEDC_BA98_7654_3210, 2'b10, 5);
        do_read(1'b0, 32'h8000_0080, 64'h0000_0001_0000_0002, 2'b00, 0);

        // Asynchronous reset in the middle of a write.
        tick();
        bus.awready = 0; bus.wready = 0;
        bus.lsu_req_valid = 1; bus.lsu_wen = 1; bus.lsu_addr = 32'h8000_6000;
        bus.lsu_wdata = 64'h0BAD_0BAD_0BAD_0BAD; bus.lsu_wstrb = 8'hFF;
        tick();
        bus.lsu_req_valid = 0; bus.lsu_wen = 0;
        check("pre_rst_aw_w", {bus.awvalid, bus.wvalid}, 2'b11);
        #2 aresetn = 0;
        #1;
        check("mid_rst_aw_w", {bus.awvalid, bus.wvalid, st}, 5'd0);
        repeat (2) tick();
        check("rst_no_rsp", {bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 2'b00);
        aresetn = 1;
        tick();
        do_read(1'b0, 32'h8000_0100, 64'hCAFE_0000_BEEF_0001, 2'b00, 0);

        // Spurious rvalid/bvalid while idle.
        tick();
        bus.rvalid = 1; bus.rdata = 64'hBAAD_F00D_BAAD_F00D; bus.bvalid = 1; bus.bresp = 2'b11;
        tick();
        check("spur_idle", {st, bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 5'd0);
        tick();
        check("spur_idle2", {st, bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 5'd0);
        bus.rvalid = 0; bus.bvalid = 0; bus.rdata = '0; bus.bresp = '0;
        tick();

        // Round-robin instance: four ties alternate IFU, LSU, IFU, LSU.
        for (int i = 0; i < 4; i++) begin
            exp_rr_q.push_back(rr_order[i]);
            bus_rr.ifu_req_valid = 1; bus_rr.ifu_addr = 32'h8000_0000 + 32'(i * 8);
            bus_rr.lsu_req_valid = 1; bus_rr.lsu_wen = 0; bus_rr.lsu_addr = 32'h8000_8000 + 32'(i * 8);
            tick();
            bus_rr.ifu_req_valid = 0; bus_rr.lsu_req_valid = 0;
            check("rr_ar", {st_rr, bus_rr.arvalid}, {3'd1, 1'b1});
            tick();
            bus_rr.rvalid = 1; bus_rr.rdata = 64'(i);
            tick();
            bus_rr.rvalid = 0;
            tick();
        end

        repeat (2) tick();
        check("drain", exp_q.size(), 0);
        check("drain_rr", exp_rr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
